// File: rtl/hero_pkg.sv
// Shared definitions for the hero controller and its button front end.
//   - Direction indices: bit positions in every 5-bit button vector
//     {center, down, right, left, up}.
//   - FSM state encoding for the move-pulse generator.
//   - dir_onehot(): one-hot 4-bit move vector for a 2-bit direction index.
package hero_pkg;

  localparam int NUM_BTN    = 5;
  localparam int NUM_DIR    = 4;

  localparam int DIR_UP     = 0;
  localparam int DIR_LEFT   = 1;
  localparam int DIR_RIGHT  = 2;
  localparam int DIR_DOWN   = 3;
  localparam int DIR_CENTER = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Movement directions occupy indices 0..3, so a 2-bit index is enough.
  function automatic logic [NUM_DIR-1:0] dir_onehot(input logic [1:0] dir);
    logic [NUM_DIR-1:0] oh;
    oh = '0;
    oh[dir] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a counting debouncer for one raw button.
//   clk_i   : system clock
//   rst_i   : synchronous, active-high reset
//   btn_i   : raw asynchronous button level
//   level_o : debounced (registered) level
// The debounced level only follows the synchronised input once that input
// has differed from it for DEBOUNCE_CYCLES consecutive cycles; any return
// to the current level restarts the count from zero.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int CNT_W           = 21
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o
);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      // Input has disagreed long enough: accept the new level.
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = stable_q;

endmodule

// File: rtl/move_cmd_gen.sv
// Button front end for the hero controller.
//   clk, rst                      : clock, synchronous active-high reset
//   btn_up/left/right/down/center : raw asynchronous buttons
//   up/left/right/down            : one-cycle move pulses (mutually exclusive)
//   center                        : one-cycle attack pulse on debounced press
//   btn_state                     : debounced levels {center,down,right,left,up}
// A held direction yields a pulse DEBOUNCE_CYCLES+3 cycles after the raw
// press and then one every MOVE_PERIOD cycles. Priority is
// up > left > right > down; the winner is re-evaluated at every pulse.
module move_cmd_gen
  import hero_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int MOVE_PERIOD     = 162500,
  parameter int CNT_W           = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_center,
  output logic       up,
  output logic       left,
  output logic       right,
  output logic       down,
  output logic       center,
  output logic [4:0] btn_state
);

  localparam logic [CNT_W-1:0] PERIOD_RELOAD = CNT_W'(MOVE_PERIOD - 1);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] stable;

  // Bit order matches the DIR_* indices.
  assign raw = {btn_center, btn_down, btn_right, btn_left, btn_up};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .clk_i   (clk),
      .rst_i   (rst),
      .btn_i   (raw[i]),
      .level_o (stable[i])
    );
  end

  // Priority resolver over the debounced levels.
  logic       win_valid;
  logic [1:0] win_dir;

  always_comb begin
    win_valid = 1'b1;
    win_dir   = 2'(DIR_UP);
    if (stable[DIR_UP]) begin
      win_dir = 2'(DIR_UP);
    end else if (stable[DIR_LEFT]) begin
      win_dir = 2'(DIR_LEFT);
    end else if (stable[DIR_RIGHT]) begin
      win_dir = 2'(DIR_RIGHT);
    end else if (stable[DIR_DOWN]) begin
      win_dir = 2'(DIR_DOWN);
    end else begin
      win_valid = 1'b0;
    end
  end

  state_t             state_q;
  logic [CNT_W-1:0]   period_q;
  logic [NUM_DIR-1:0] move_q;
  logic               center_q;
  logic               center_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      period_q      <= '0;
      move_q        <= '0;
      center_q      <= 1'b0;
      center_prev_q <= 1'b0;
    end else begin
      // Pulses default low so each lasts exactly one cycle.
      move_q        <= '0;
      center_prev_q <= stable[DIR_CENTER];
      center_q      <= stable[DIR_CENTER] & ~center_prev_q;

      case (state_q)
        IDLE: begin
          if (win_valid) begin
            move_q   <= dir_onehot(win_dir);
            period_q <= PERIOD_RELOAD;
            state_q  <= HOLD;
          end
        end
        HOLD: begin
          if (!win_valid) begin
            state_q <= IDLE;
          end else if (period_q == '0) begin
            // A direction change mid-period is only seen here.
            move_q   <= dir_onehot(win_dir);
            period_q <= PERIOD_RELOAD;
          end else begin
            period_q <= period_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign up        = move_q[DIR_UP];
  assign left      = move_q[DIR_LEFT];
  assign right     = move_q[DIR_RIGHT];
  assign down      = move_q[DIR_DOWN];
  assign center    = center_q;
  assign btn_state = stable;

endmodule
